// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one data-memory master port.
// Masters drive the request side; the arbiter drives gnt and the response.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data SRAM.
// CPU has fixed priority; a wait counter guards master 1 from starvation.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [15:0] BASE_HI  = 16'h1000
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic          mem_we,
  output logic [13:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_q, wait_d;
  logic [13:0]   addr_q;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_owner_q, rsp_owner_d;
  logic          rsp_read_q, rsp_read_d;
  logic          rsp_err_q, rsp_err_d;

  logic        starve;
  logic        gnt0, gnt1, any_gnt;
  logic        win_we;
  logic [31:0] win_addr;
  logic        in_win;
  logic        rv0, rv1, rd_ok;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0.addr[1:0], m1.addr[1:0]};

  // Combinational grant: CPU first unless master 1 has waited too long.
  always_comb begin
    starve  = (wait_q == WAIT_MAX) && m1.req;
    gnt1    = !rst && m1.req && (!m0.req || starve);
    gnt0    = !rst && m0.req && !gnt1;
    any_gnt = gnt0 || gnt1;
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // Winner mux, window decode and SRAM drive.
  always_comb begin
    win_we    = gnt1 ? m1.we    : m0.we;
    win_addr  = gnt1 ? m1.addr  : m0.addr;
    mem_wdata = gnt1 ? m1.wdata : m0.wdata;
    mem_wstrb = gnt1 ? m1.wstrb : m0.wstrb;
    in_win    = win_addr[31:16] == BASE_HI;
    mem_we    = any_gnt && win_we && in_win;
    mem_addr  = any_gnt ? win_addr[15:2] : addr_q;
  end

  // Next-state for the starvation counter and response stage.
  always_comb begin
    wait_d = wait_q;
    if (!m1.req || gnt1) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
    rsp_valid_d = any_gnt;
    rsp_owner_d = gnt1;
    rsp_read_d  = any_gnt && !win_we;
    rsp_err_d   = any_gnt && !in_win;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q      <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_read_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      addr_q      <= mem_addr;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_read_q  <= rsp_read_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Response steering; rst squashes a response already in the stage.
  always_comb begin
    rv0       = !rst && rsp_valid_q && !rsp_owner_q;
    rv1       = !rst && rsp_valid_q && rsp_owner_q;
    rd_ok     = rsp_read_q && !rsp_err_q;
    m0.rvalid = rv0;
    m1.rvalid = rv1;
    m0.err    = rv0 && rsp_err_q;
    m1.err    = rv1 && rsp_err_q;
    m0.rdata  = (rv0 && rd_ok) ? mem_rdata : 32'h0;
    m1.rdata  = (rv1 && rd_ok) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: SRAM model, reference memory and a
// response scoreboard, plus per-scenario directed checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter #(.MAX_WAIT(4), .BASE_HI(16'h1000)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic [31:0] sram [16384];
  logic [31:0] ref_mem [16384];
  rsp_t        sb [$];
  int          checks = 0;
  int          passes = 0;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      sram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
  end

  // Synchronous-read, byte-strobed SRAM.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= sram[mem_addr];
  end

  function automatic rsp_t accept(input logic owner, input logic we,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s);
    rsp_t r;
    logic inw;
    logic [13:0] idx;
    inw = a[31:16] == 16'h1000;
    idx = a[15:2];
    r.owner = owner;
    r.err   = !inw;
    r.rdata = (!we && inw) ? ref_mem[idx] : 32'h0;
    if (we && inw)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Scoreboard: pop last cycle's expectation, then push this cycle's.
  always @(negedge clk) begin
    logic [67:0] got, exp;
    rsp_t e;
    got = {m0_if.rvalid, m0_if.err, m0_if.rdata,
           m1_if.rvalid, m1_if.err, m1_if.rdata};
    if (rst) begin
      sb.delete();
      exp = '0;
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      exp = e.owner ? {34'h0, 1'b1, e.err, e.rdata}
                    : {1'b1, e.err, e.rdata, 34'h0};
    end else begin
      exp = '0;
    end
    checks++;
    if (got !== exp)
      $display("FAIL rsp t=%0t got %h exp %h", $time, got, exp);
    else
      passes++;
    if (!rst) begin
      checks++;
      if ((m0_if.gnt && m1_if.gnt) !== 1'b0)
        $display("FAIL one_gnt t=%0t got both granted exp 0", $time);
      else
        passes++;
      if (m0_if.req && m0_if.gnt)
        sb.push_back(accept(1'b0, m0_if.we, m0_if.addr,
                            m0_if.wdata, m0_if.wstrb));
      if (m1_if.req && m1_if.gnt)
        sb.push_back(accept(1'b1, m1_if.we, m1_if.addr,
                            m1_if.wdata, m1_if.wstrb));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m0_if.req = r; m0_if.we = w; m0_if.addr = a;
    m0_if.wdata = d; m0_if.wstrb = s;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m1_if.req = r; m1_if.we = w; m1_if.addr = a;
    m1_if.wdata = d; m1_if.wstrb = s;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_m0(1'b1, 1'b1, 32'h1000_0000, 32'h5555_5555, 4'hF);
    set_m1(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0);
    repeat (2) begin
      nxt();
      @(negedge clk);
      checks++;
      if ({m0_if.gnt, m1_if.gnt, mem_we} !== 3'b000)
        $display("FAIL reset_out got %b exp 000",
                 {m0_if.gnt, m1_if.gnt, mem_we});
      else
        passes++;
    end
    nxt();
    rst = 1'b0;
    idle();
    @(negedge clk);
  endtask

  task automatic test_single();
    nxt();
    set_m0(1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr} !== {1'b1, 14'h0004})
      $display("FAIL single_wr got %b/%h exp 1/0004", mem_we, mem_addr);
    else
      passes++;
    nxt();
    set_m0(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if ({m0_if.rvalid, mem_we} !== 2'b10)
      $display("FAIL single_wack got %b exp 10", {m0_if.rvalid, mem_we});
    else
      passes++;
    nxt();
    idle();
    @(negedge clk);
    checks++;
    if ({m0_if.rvalid, m0_if.err, m0_if.rdata} !== {2'b10, 32'hDEAD_BEEF})
      $display("FAIL single_rd got %h exp DEADBEEF", m0_if.rdata);
    else
      passes++;
  endtask

  task automatic test_strobe();
    nxt();
    set_m0(1'b1, 1'b1, 32'h1000_0020, 32'hFFFF_FFFF, 4'hF);
    nxt();
    set_m0(1'b1, 1'b1, 32'h1000_0020, 32'h1122_3344, 4'b0101);
    nxt();
    set_m0(1'b1, 1'b1, 32'h1000_0020, 32'hAAAA_AAAA, 4'h0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1)
      $display("FAIL zero_strb_we got %b exp 1", mem_we);
    else
      passes++;
    nxt();
    set_m0(1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'h0);
    nxt();
    idle();
    @(negedge clk);
    checks++;
    if (m0_if.rdata !== 32'hFF22_FF44)
      $display("FAIL strobe_rd got %h exp FF22FF44", m0_if.rdata);
    else
      passes++;
  endtask

  task automatic test_contention();
    nxt();
    set_m0(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0);
    set_m1(1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      logic [1:0] e;
      @(negedge clk);
      e = (i % 5 == 4) ? 2'b01 : 2'b10;
      checks++;
      if ({m0_if.gnt, m1_if.gnt} !== e)
        $display("FAIL contention[%0d] got %b exp %b", i,
                 {m0_if.gnt, m1_if.gnt}, e);
      else
        passes++;
      nxt();
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_oow();
    nxt();
    set_m1(1'b1, 1'b1, 32'h2000_0000, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    checks++;
    if ({m1_if.gnt, mem_we} !== 2'b10)
      $display("FAIL oow_we got %b exp 10", {m1_if.gnt, mem_we});
    else
      passes++;
    nxt();
    set_m1(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if ({m1_if.rvalid, m1_if.err} !== 2'b11)
      $display("FAIL oow_err got %b exp 11", {m1_if.rvalid, m1_if.err});
    else
      passes++;
    nxt();
    idle();
    @(negedge clk);
    checks++;
    if ({m1_if.rvalid, m1_if.err, m1_if.rdata} !== {2'b10, 32'h0})
      $display("FAIL oow_after got %b/%h exp 10/0",
               {m1_if.rvalid, m1_if.err}, m1_if.rdata);
    else
      passes++;
  endtask

  task automatic test_back_to_back();
    nxt();
    set_m0(1'b1, 1'b1, 32'h1000_0030, 32'h1234_5678, 4'hF);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nxt();
    set_m0(1'b1, 1'b0, 32'h1000_0032, 32'h0, 4'h0);
    nxt();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b1, 1'b0, 32'h1000_0030, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (m0_if.rdata !== 32'h1234_5678)
      $display("FAIL b2b_rd got %h exp 12345678", m0_if.rdata);
    else
      passes++;
    nxt();
    idle();
    @(negedge clk);
    checks++;
    if (m1_if.rdata !== 32'h1234_5678)
      $display("FAIL b2b_m1 got %h exp 12345678", m1_if.rdata);
    else
      passes++;
  endtask

  task automatic test_reset_mid();
    nxt();
    set_m0(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0);
    set_m1(1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'h0);
    repeat (2) nxt();
    nxt();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_if.rvalid, m0_if.gnt, m1_if.gnt, mem_we} !== 4'b0000)
        $display("FAIL rst_mid[%0d] got %b exp 0000", i,
                 {m0_if.rvalid, m0_if.gnt, m1_if.gnt, mem_we});
      else
        passes++;
      nxt();
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] e;
      @(negedge clk);
      e = (i == 4) ? 2'b01 : 2'b10;
      checks++;
      if ({m0_if.gnt, m1_if.gnt} !== e)
        $display("FAIL rst_wait[%0d] got %b exp %b", i,
                 {m0_if.gnt, m1_if.gnt}, e);
      else
        passes++;
      nxt();
    end
    idle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_strobe();
    test_contention();
    test_oow();
    test_back_to_back();
    test_reset_mid();
    repeat (2) nxt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed in front of the single-port 64 KB data SRAM (0x10000000–0x1000FFFF, 16384 × 32-bit, synchronous read, byte-strobed write). It shares the SRAM between the CPU load/store port (master 0) and the DMA/crypto engine port (master 1). It issues at most one SRAM access per cycle with fixed priority to the CPU and a starvation guard for master 1. It also decodes the address window and returns an error response for out-of-window accesses without touching memory.

## Interface
- MAX_WAIT, 4: consecutive denied cycles after which master 1 takes priority over master 0; legal range 1–15.
- BASE_HI, 16'h1000: required value of addr[31:16] for an in-window access.

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mN_req  in  1  request from master N (N = 0, 1)
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  32  byte address; word index = addr[15:2]; addr[1:0] ignored
- mN_wdata  in  32  write data
- mN_wstrb  in  4  byte enables for writes
- mN_gnt  out  1  combinational accept; transfer occurs in a cycle where req && gnt
- mN_rvalid  out  1  response strobe, exactly one per accepted request
- mN_rdata  out  32  read data, meaningful only while mN_rvalid
- mN_err  out  1  out-of-window flag, meaningful only while mN_rvalid
- mem_we  out  1  SRAM write enable
- mem_addr  out  14  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_wstrb  out  4  SRAM byte strobes
- mem_rdata  in  32  SRAM read data, valid one cycle after the address is presented

## Operation
- Arbitration is combinational each cycle.
  - Default: master 0 wins if m0_req.
  - Starvation override: if wait_cnt == MAX_WAIT and m1_req, master 1 wins even when m0_req is high.
  - Otherwise master 1 wins only when m0_req is low.
  - At most one gnt is high per cycle. Both gnt are 0 while rst is high.
- wait_cnt is a saturating counter of width clog2(MAX_WAIT+1).
  - Increments when m1_req && !m1_gnt.
  - Clears when m1_gnt or !m1_req.
  - Holds at MAX_WAIT once saturated.
  - Resets to 0.
- Memory drive:
  - mem_addr = winner addr[15:2] whenever any grant is active; otherwise it holds its last value (don't-care).
  - mem_wdata and mem_wstrb are passed through from the winner.
  - mem_we = granted && winner we && in-window, where in-window means addr[31:16] == BASE_HI.
  - An out-of-window write never asserts mem_we.
  - A write with wstrb == 0 still asserts mem_we and is acked normally.
- Response pipeline: one register stage holds the following fields.
  - rsp_valid: reset 0.
  - rsp_owner: reset 0.
  - rsp_read: reset 0.
  - rsp_err: reset 0.
  - These are loaded every cycle from the current grant; rsp_valid = 0 when no grant.
- Response outputs:
  - mN_rvalid = rsp_valid && rsp_owner == N.
  - mN_err = mN_rvalid && rsp_err.
  - mN_rdata = mem_rdata when mN_rvalid && rsp_read && !rsp_err; otherwise 32'h0.
- Writes are acked with rvalid (rdata = 0) in the cycle after acceptance.
- No outstanding-request limit. The block is fully pipelined: one accept per cycle, one response per cycle.

## Timing
- Accept at cycle T: mem_* driven in T, the SRAM samples at the T→T+1 edge, and mN_rvalid/rdata/err appear in T+1. Latency is exactly 1 cycle for reads, writes and errors.
- Back-to-back accesses:
  - A write in T followed by a read of the same word in T+1 returns the new data in T+2.
  - Responses are returned in grant order.
- Reset outputs: all mN_rvalid = 0, mN_err = 0, mN_rdata = 0, mem_we = 0, both gnt = 0.
- Reset mid-operation: an access accepted in the cycle before rst has its response suppressed (rvalid = 0 during and after reset). An SRAM write already issued at that edge completes.
- Masters must hold req/we/addr/wdata/wstrb stable until gnt. Dropping req before gnt is legal and resets wait_cnt.

## Test plan
- Single master: m0 writes 0xDEADBEEF to 0x10000010 with wstrb = 4'hF, then reads it → mem_we = 1 and mem_addr = 14'h0004 in the write cycle; m0_rvalid in each following cycle; read returns 0xDEADBEEF with err = 0.
- Byte strobes: write 0x11223344 with wstrb = 4'b0101 over 0xFFFFFFFF, then read → 0xFF22FF44.
- Contention: m0 and m1 both request continuously with MAX_WAIT = 4 → grant pattern m0,m0,m0,m0,m1, repeating; wait_cnt clears after each m1 grant; rvalids alternate owners accordingly.
- Out-of-window: m1 writes 0x20000000 → mem_we stays 0; m1_rvalid = 1 and m1_err = 1 next cycle; a subsequent in-window read of word 0 is unaffected.
- Reset mid-flight: m0 read accepted in cycle T, rst asserted in T+1 → m0_rvalid = 0 in T+1; all outputs at reset values; wait_cnt = 0 after release.
